mem_access: RTL

Data-memory stage of the sequential Y86-64 core. It sits directly downstream of the execute stage: it consumes `icode`, `valE`, `valA` and `valP` for the current instruction, performs the architecturally required 64-bit load or store over a byte-wide data-memory port, and returns `valM` plus a completion/error indication to the writeback/PC-update logic.

---
 rtl/mem_access.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: data-memory stage of the sequential Y86-64 core.
// Decodes icode into a 64-bit load or store and moves it one byte per
// accepted cycle over a byte-wide memory port, little-endian. The access is
// range-checked before any strobe is raised. Results are returned as valM,
// a one-cycle done pulse and dmem_error.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request pulse, honoured only while idle
//   icode, valE, valA,   operands from execute
//   valP
//   valM                 loaded word (0 for stores, no-access and errors)
//   done                 one-cycle completion pulse
//   dmem_error           address out of range; held until next accepted start
//   busy                 high while not idle
//   mem_addr, mem_wdata  byte address and write byte
//   mem_re, mem_we       byte read / write strobes
//   mem_rdata, mem_ready read byte and per-byte handshake from memory
module mem_access #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        done,
  output logic        dmem_error,
  output logic        busy,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  // Highest legal start address of an 8-byte word.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_SIZE) - 64'd8;

  state_t      state, state_next;
  logic [63:0] addr;
  logic [63:0] data;
  logic        is_write;
  logic [2:0]  idx;

  logic        req_access;
  logic        req_write;
  logic        req_err;
  logic [63:0] req_addr;
  logic [63:0] req_data;

  // Access decode for the instruction presented with start.
  always_comb begin
    req_access = 1'b0;
    req_write  = 1'b0;
    req_addr   = valE;
    req_data   = valA;
    case (icode)
      4'h4: begin req_access = 1'b1; req_write = 1'b1; end
      4'h5: begin req_access = 1'b1; end
      4'h8: begin req_access = 1'b1; req_write = 1'b1; req_data = valP; end
      4'h9: begin req_access = 1'b1; req_addr = valA; end
      4'hA: begin req_access = 1'b1; req_write = 1'b1; end
      4'hB: begin req_access = 1'b1; req_addr = valA; end
      default: ;
    endcase
    // Full 64-bit compare: huge addresses must not wrap back into range.
    req_err = req_addr > LAST_ADDR;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (req_access && !req_err) ? XFER : DONE;
      XFER: if (mem_ready && idx == 3'd7) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      data       <= '0;
      is_write   <= 1'b0;
      idx        <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          addr       <= req_addr;
          data       <= req_data;
          is_write   <= req_write;
          idx        <= '0;
          valM       <= '0;
          dmem_error <= req_access && req_err;
        end
        XFER: if (mem_ready) begin
          if (!is_write) valM[{idx, 3'b000} +: 8] <= mem_rdata;
          idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Port outputs decode registered state only, so they move on clock edges.
  always_comb begin
    busy      = state != IDLE;
    done      = state == DONE;
    mem_re    = (state == XFER) && !is_write;
    mem_we    = (state == XFER) && is_write;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == XFER) begin
      mem_addr = addr + 64'(idx);
      if (is_write) mem_wdata = data[{idx, 3'b000} +: 8];
    end
  end

endmodule
